// File: rtl/inst_encoder_loader.sv
// Program loader: encodes symbolic MIPS instructions, queues them and writes them into instruction memory.
// Optional macro INST_ENC_BRANCH_REL_EN: beq offset computed from an absolute byte target.
module inst_encoder_loader #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              load_end,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              InstM_CS,
  output logic              InstM_W,
  output logic [ADDR_W-1:0] InstM_addr,
  output logic [31:0]       InstM_data,
  input  logic              InstM_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] count,
  output logic [1:0]        fsm_state
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] push_addr, wr_addr;
  logic [31:0]       mem [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [PW:0]       fcnt;
  logic              fifo_full, fifo_empty, push, pop, wr_active;
  logic [15:0]       beq_imm;
  logic [31:0]       enc_word;

  assign fifo_full  = (fcnt == (PW+1)'(DEPTH));
  assign fifo_empty = (fcnt == '0);
  assign push       = in_valid && in_ready;
  assign pop        = InstM_CS && InstM_ready;
  assign wr_active  = (state == RUN) || (state == DRAIN);
  assign fsm_state  = state;

`ifdef INST_ENC_BRANCH_REL_EN
  logic signed [ADDR_W-1:0] br_diff, br_shift;
  always_comb begin
    br_diff  = signed'({in_target[ADDR_W-1:2], 2'b00} - (push_addr + ADDR_W'(4)));
    br_shift = br_diff >>> 2;
    beq_imm  = 16'(br_shift);
  end
`else
  assign beq_imm = in_imm;
`endif

  always_comb begin
    enc_word = '0;
    case (in_kind)
      3'd0: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100001};
      3'd1: enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100011};
      3'd2: enc_word = {6'b000000, 5'b00000, in_rt, in_rd, in_shamt, 6'b000000};
      3'd3: enc_word = {6'b001101, in_rs, in_rt, in_imm};
      3'd4: enc_word = {6'b100011, in_rs, in_rt, in_imm};
      3'd5: enc_word = {6'b101011, in_rs, in_rt, in_imm};
      3'd6: enc_word = {6'b000100, in_rs, in_rt, beq_imm};
      default: enc_word = {6'b000010, in_target};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_start) state_nxt = RUN;
      RUN:     if (load_end) state_nxt = DRAIN;
      DRAIN:   if (fifo_empty && !InstM_CS) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    done     = (state == DONE);
    in_ready = (state == RUN) && !fifo_full;
  end

  // Storage needs no reset; emptiness is carried by the occupancy counter.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= enc_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      fcnt <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      fcnt <= fcnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      push_addr <= '0;
      wr_addr   <= '0;
      count     <= '0;
    end else begin
      if (state == IDLE && load_start) begin
        push_addr <= start_addr;
        wr_addr   <= start_addr;
        count     <= '0;
      end
      if (push) push_addr <= push_addr + ADDR_W'(4);
      if (pop) begin
        wr_addr <= wr_addr + ADDR_W'(4);
        count   <= count + ADDR_W'(1);
      end
    end
  end

  // Each word is presented from registers and held until accepted; the
  // cycle after acceptance is always idle, so writes are at most 1 per 2 cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      InstM_CS   <= 1'b0;
      InstM_W    <= 1'b0;
      InstM_addr <= '0;
      InstM_data <= '0;
    end else if (InstM_CS) begin
      if (InstM_ready) begin
        InstM_CS   <= 1'b0;
        InstM_W    <= 1'b0;
        InstM_addr <= '0;
        InstM_data <= '0;
      end
    end else if (wr_active && !fifo_empty) begin
      InstM_CS   <= 1'b1;
      InstM_W    <= 1'b1;
      InstM_addr <= wr_addr;
      InstM_data <= mem[rptr];
    end
  end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader: hand-encoded words checked against memory writes.
module tb_inst_encoder_loader;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n, load_start, load_end, in_valid, InstM_ready;
  logic [AW-1:0] start_addr;
  logic [2:0]    in_kind;
  logic [4:0]    in_rs, in_rt, in_rd, in_shamt;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          in_ready, InstM_CS, InstM_W, busy, done;
  logic [AW-1:0] InstM_addr, count;
  logic [31:0]   InstM_data;
  logic [1:0]    fsm_state;

  int checks = 0;
  int failures = 0;
  logic [AW+31:0] exp_q[$];
  logic [AW-1:0]  exp_addr;

  inst_encoder_loader #(.ADDR_W(AW), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .start_addr(start_addr),
    .load_end(load_end), .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_target(in_target), .InstM_CS(InstM_CS), .InstM_W(InstM_W), .InstM_addr(InstM_addr),
    .InstM_data(InstM_data), .InstM_ready(InstM_ready), .busy(busy), .done(done),
    .count(count), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Scoreboard: every accepted write must match the head of exp_q; stalled writes must hold.
  logic           stalled = 1'b0;
  logic [AW+31:0] held;
  always @(negedge clk) begin
    if (InstM_CS) begin
      check("write_strobe", InstM_W, 1'b1);
      if (stalled) check("hold_addr_data", {InstM_addr, InstM_data}, held);
      if (InstM_ready) begin
        if (exp_q.size() == 0) check("unexpected_write", {InstM_addr, InstM_data}, '0);
        else check("write_addr_data", {InstM_addr, InstM_data}, exp_q.pop_front());
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = {InstM_addr, InstM_data};
      end
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input logic [AW-1:0] a);
    start_addr = a;
    load_start = 1'b1;
    exp_addr = a;
    tick(1);
    load_start = 1'b0;
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic push_word(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                           input logic [25:0] tgt, input logic [31:0] expw);
    int n = 0;
    in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
    in_imm = imm; in_target = tgt;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      tick(1);
      n++;
    end
    if (!in_ready) begin
      check("push_timeout", in_ready, 1'b1);
    end else begin
      exp_q.push_back({exp_addr, expw});
      exp_addr = exp_addr + AW'(4);
      tick(1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    tick(1);
  endtask

  task automatic finish_session(input logic [AW-1:0] exp_count);
    int n = 0;
    load_end = 1'b1;
    tick(1);
    load_end = 1'b0;
    while (!done && n < 200) begin
      tick(1);
      n++;
    end
    check("done_seen", done, 1'b1);
    check("count_at_done", count, exp_count);
    tick(1);
    check("done_one_cycle", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
    check("queue_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    check("rst_cs", InstM_CS, 1'b0);
    check("rst_w", InstM_W, 1'b0);
    check("rst_addr", InstM_addr, '0);
    check("rst_data", InstM_data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_count", count, '0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_state", fsm_state, 2'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; load_start = 1'b0; load_end = 1'b0; in_valid = 1'b0; InstM_ready = 1'b0;
    start_addr = '0; in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
    in_imm = '0; in_target = '0; exp_addr = '0;
    tick(1);
    do_reset();

    // Single addu, memory always ready
    InstM_ready = 1'b1;
    start(16'h0000);
    push_word(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h00221821);
    wait_drain();
    check("count_one", count, 16'd1);
    finish_session(16'd1);

    // Four kinds at consecutive addresses; unused fields carry junk
    start(16'h0000);
    push_word(3'd3, 5'd0, 5'd5, 5'd9, 5'd3, 16'h00FF, 26'h155, 32'h340500FF);
    push_word(3'd4, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 32'h8FA80004);
    push_word(3'd2, 5'd7, 5'd2, 5'd4, 5'd3, 16'hBEEF, 26'h0, 32'h000220C0);
    push_word(3'd7, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1234, 26'h10, 32'h08000010);
    finish_session(16'd4);

    // Stalled memory: FIFO fills at 4, first word frozen, then all 6 in order
    InstM_ready = 1'b0;
    start(16'h0100);
    push_word(3'd1, 5'd3, 5'd4, 5'd5, 5'd0, 16'h0, 26'h0, 32'h00642823);
    push_word(3'd5, 5'd2, 5'd7, 5'd0, 5'd0, 16'h0010, 26'h0, 32'hAC470010);
    push_word(3'd0, 5'd31, 5'd31, 5'd31, 5'd0, 16'h0, 26'h0, 32'h03FFF821);
    push_word(3'd4, 5'd0, 5'd1, 5'd0, 5'd0, 16'h8000, 26'h0, 32'h8C018000);
    check("full_in_ready", in_ready, 1'b0);
    tick(6);
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_cs", InstM_CS, 1'b1);
    check("stall_addr", InstM_addr, 16'h0100);
    check("stall_data", InstM_data, 32'h00642823);
    InstM_ready = 1'b1;
    push_word(3'd3, 5'd7, 5'd7, 5'd0, 5'd0, 16'hABCD, 26'h0, 32'h34E7ABCD);
    push_word(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFF, 32'h0BFFFFFF);
    finish_session(16'd6);

    // load_end with two words queued, then input refused while idle
    InstM_ready = 1'b0;
    start(16'h0200);
    push_word(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h00221821);
    push_word(3'd2, 5'd0, 5'd2, 5'd4, 5'd3, 16'h0, 26'h0, 32'h000220C0);
    load_end = 1'b1;
    tick(1);
    load_end = 1'b0;
    check("drain_in_ready", in_ready, 1'b0);
    tick(2);
    InstM_ready = 1'b1;
    finish_session(16'd2);
    in_valid = 1'b1;
    tick(4);
    check("idle_in_ready", in_ready, 1'b0);
    check("idle_cs", InstM_CS, 1'b0);
    in_valid = 1'b0;

    // Address wrap
    start(16'hFFFC);
    push_word(3'd3, 5'd0, 5'd5, 5'd0, 5'd0, 16'h00FF, 26'h0, 32'h340500FF);
    push_word(3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 32'h08000010);
    finish_session(16'd2);

    // beq: relative target when the macro is on, raw imm otherwise
    start(16'h0010);
`ifdef INST_ENC_BRANCH_REL_EN
    push_word(3'd6, 5'd1, 5'd2, 5'd0, 5'd0, 16'h1234, 26'h20, 32'h10220003);
`else
    push_word(3'd6, 5'd1, 5'd2, 5'd0, 5'd0, 16'h1234, 26'h20, 32'h10221234);
`endif
    finish_session(16'd1);

    // Reset during a stalled write aborts it and empties the FIFO
    InstM_ready = 1'b0;
    start(16'h0300);
    push_word(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h00221821);
    tick(3);
    check("pre_rst_cs", InstM_CS, 1'b1);
    exp_q.delete();
    do_reset();
    InstM_ready = 1'b1;
    start(16'h0040);
    finish_session(16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
